// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer: 8N1 UART receiver with a one-entry valid/ready holding register
module uart_rx_deserializer #(
    parameter int CLKS_PER_BIT = 217,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 uart_rx_input,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_error,
    output logic                 overrun,
    output logic                 rx_busy
);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t state, state_n;
    logic rx_meta, rxs;
    logic [15:0] cnt, cnt_n;
    logic [BW-1:0] bit_cnt, bit_cnt_n;
    logic [DATA_BITS-1:0] sh, sh_n, rx_data_n;
    logic rx_valid_n, frame_error_n, overrun_n;

    assign rx_busy = state != IDLE;

    // two-flop synchronizer; the line idles high so reset to 1 to avoid a false start
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= uart_rx_input;
            rxs     <= rx_meta;
        end
    end

    // state, counters, shift register and holding register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_cnt     <= '0;
            sh          <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            bit_cnt     <= bit_cnt_n;
            sh          <= sh_n;
            rx_data     <= rx_data_n;
            rx_valid    <= rx_valid_n;
            frame_error <= frame_error_n;
            overrun     <= overrun_n;
        end
    end

    // next-state: mid-bit sampling, stop-bit checking and holding-register load/drop
    always_comb begin
        state_n       = state;
        cnt_n         = cnt + 16'd1;
        bit_cnt_n     = bit_cnt;
        sh_n          = sh;
        rx_data_n     = rx_data;
        rx_valid_n    = rx_valid & ~rx_ready;
        frame_error_n = 1'b0;
        overrun_n     = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rxs) state_n = START;
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_n     = '0;
                    bit_cnt_n = '0;
                    state_n   = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_n         = '0;
                    sh_n[bit_cnt] = rxs;
                    bit_cnt_n     = bit_cnt + 1'b1;
                    if (bit_cnt == DATA_LAST) state_n = STOP;
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_n = '0;
                    if (rxs) begin
                        state_n = IDLE;
                        if (!rx_valid || rx_ready) begin
                            rx_data_n  = sh;
                            rx_valid_n = 1'b1;
                        end else begin
                            overrun_n = 1'b1;
                        end
                    end else begin
                        frame_error_n = 1'b1;
                        state_n       = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                cnt_n = '0;
                if (rxs) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb_uart_rx_deserializer: directed checks of the UART receiver at 16 clocks per bit
module tb_uart_rx_deserializer;
    localparam int CPB = 16;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic uart_rx_input = 1'b1;
    logic rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic rx_valid, frame_error, overrun, rx_busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int start_cyc = 0;
    int fe_cnt = 0, ov_cnt = 0, both_cnt = 0, rise_cnt = 0, rise_cyc = 0, acc_cnt = 0;
    logic [7:0] acc_last = 8'h00, acc_prev = 8'h00;
    logic prev_valid = 1'b0;
    int fe_b, ov_b, rise_b, acc_b;

    uart_rx_deserializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .uart_rx_input(uart_rx_input),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .frame_error(frame_error),
        .overrun(overrun),
        .rx_busy(rx_busy)
    );

    always #5 clock = ~clock;

    // cycle counter advanced on each active edge
    always @(posedge clock) cyc <= cyc + 1;

    // event monitor sampled on the falling edge, away from the active edge
    always @(negedge clock) begin
        if (!reset_n) begin
            prev_valid <= 1'b0;
        end else begin
            prev_valid <= rx_valid;
            if (frame_error) fe_cnt <= fe_cnt + 1;
            if (overrun) ov_cnt <= ov_cnt + 1;
            if (frame_error && overrun) both_cnt <= both_cnt + 1;
            if (rx_valid && !prev_valid) begin
                rise_cnt <= rise_cnt + 1;
                rise_cyc <= cyc;
            end
            if (rx_valid && rx_ready) begin
                acc_cnt  <= acc_cnt + 1;
                acc_last <= rx_data;
                acc_prev <= acc_last;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send_head(input logic [7:0] b);
        start_cyc = cyc;
        uart_rx_input = 1'b0;
        wait_n(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx_input = b[i];
            wait_n(CPB);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        send_head(b);
        uart_rx_input = stop;
        wait_n(CPB);
    endtask

    task automatic snap;
        fe_b = fe_cnt;
        ov_b = ov_cnt;
        rise_b = rise_cnt;
        acc_b = acc_cnt;
    endtask

    initial begin
        wait_n(3);
        chk("reset_data", 32'(rx_data), 32'h00);
        chk("reset_valid", 32'(rx_valid), 32'h0);
        chk("reset_fe", 32'(frame_error), 32'h0);
        chk("reset_ov", 32'(overrun), 32'h0);
        chk("reset_busy", 32'(rx_busy), 32'h0);
        reset_n = 1'b1;
        wait_n(5);

        snap();
        send(8'hA5, 1'b1);
        wait_n(4);
        chk("t1_valid", 32'(rx_valid), 32'h1);
        chk("t1_data", 32'(rx_data), 32'hA5);
        chk("t1_latency", 32'(rise_cyc - start_cyc), 32'd155);
        chk("t1_rises", 32'(rise_cnt - rise_b), 32'd1);
        chk("t1_fe", 32'(fe_cnt - fe_b), 32'd0);
        chk("t1_ov", 32'(ov_cnt - ov_b), 32'd0);
        rx_ready = 1'b1;
        wait_n(1);
        rx_ready = 1'b0;
        chk("t1_valid_clr", 32'(rx_valid), 32'h0);
        wait_n(3);

        snap();
        rx_ready = 1'b1;
        send(8'h3C, 1'b1);
        send(8'hC3, 1'b1);
        wait_n(20);
        rx_ready = 1'b0;
        chk("t2_acc_cnt", 32'(acc_cnt - acc_b), 32'd2);
        chk("t2_first", 32'(acc_prev), 32'h3C);
        chk("t2_second", 32'(acc_last), 32'hC3);
        chk("t2_ov", 32'(ov_cnt - ov_b), 32'd0);
        chk("t2_valid", 32'(rx_valid), 32'h0);

        snap();
        send(8'h11, 1'b1);
        send(8'h22, 1'b1);
        wait_n(4);
        chk("t3_data_kept", 32'(rx_data), 32'h11);
        chk("t3_valid", 32'(rx_valid), 32'h1);
        chk("t3_ov_once", 32'(ov_cnt - ov_b), 32'd1);
        send_head(8'h33);
        uart_rx_input = 1'b1;
        wait_n(9);
        rx_ready = 1'b1;
        wait_n(1);
        rx_ready = 1'b0;
        wait_n(6);
        wait_n(4);
        chk("t3_data_new", 32'(rx_data), 32'h33);
        chk("t3_valid_new", 32'(rx_valid), 32'h1);
        chk("t3_ov_none", 32'(ov_cnt - ov_b), 32'd1);
        rx_ready = 1'b1;
        wait_n(1);
        rx_ready = 1'b0;
        chk("t3_valid_clr", 32'(rx_valid), 32'h0);
        wait_n(3);

        snap();
        uart_rx_input = 1'b0;
        wait_n(3);
        uart_rx_input = 1'b1;
        wait_n(1);
        chk("t4_busy_start", 32'(rx_busy), 32'h1);
        wait_n(20);
        chk("t4_busy_end", 32'(rx_busy), 32'h0);
        chk("t4_rises", 32'(rise_cnt - rise_b), 32'd0);
        chk("t4_fe", 32'(fe_cnt - fe_b), 32'd0);

        snap();
        send(8'h55, 1'b0);
        wait_n(40 * CPB);
        chk("t5_busy_break", 32'(rx_busy), 32'h1);
        uart_rx_input = 1'b1;
        wait_n(20);
        chk("t5_fe_once", 32'(fe_cnt - fe_b), 32'd1);
        chk("t5_rises", 32'(rise_cnt - rise_b), 32'd0);
        chk("t5_valid", 32'(rx_valid), 32'h0);
        chk("t5_busy_idle", 32'(rx_busy), 32'h0);
        send(8'h0F, 1'b1);
        wait_n(4);
        chk("t5_next_valid", 32'(rx_valid), 32'h1);
        chk("t5_next_data", 32'(rx_data), 32'h0F);
        chk("fe_ov_exclusive", 32'(both_cnt), 32'd0);

        uart_rx_input = 1'b0;
        wait_n(CPB);
        uart_rx_input = 1'b1;
        wait_n(4 * CPB + CPB / 2);
        reset_n = 1'b0;
        wait_n(1);
        chk("t6_rst_data", 32'(rx_data), 32'h00);
        chk("t6_rst_valid", 32'(rx_valid), 32'h0);
        chk("t6_rst_busy", 32'(rx_busy), 32'h0);
        chk("t6_rst_fe", 32'(frame_error), 32'h0);
        chk("t6_rst_ov", 32'(overrun), 32'h0);
        wait_n(2);
        reset_n = 1'b1;
        snap();
        wait_n(200);
        chk("t6_no_partial", 32'(rise_cnt - rise_b), 32'd0);
        chk("t6_valid_idle", 32'(rx_valid), 32'h0);
        send(8'h81, 1'b1);
        wait_n(4);
        chk("t6_valid", 32'(rx_valid), 32'h1);
        chk("t6_data", 32'(rx_data), 32'h81);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_rx_deserializer.md
Name: uart_rx_deserializer

Overview:
- Receive half of the MCU UART. Samples the asynchronous `uart_rx_input` pin and recovers 8N1 frames, LSB first.
- Presents each received byte to the peripheral bus side through a one-entry holding register with a valid/ready handshake.
- Reports framing errors and overruns as single-cycle pulses.
- Sits between the top-level `uart_rx_input` pin and the UART register block, mirroring the existing transmitter that drives `uart_tx_output`.

Parameters:
- CLKS_PER_BIT, 217, clock cycles per bit period (25 MHz / 115200 baud); legal range 4..65535.
- DATA_BITS, 8, data bits per frame; fixed at 8 for this revision.

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- uart_rx_input  input  1  serial line, idle high, asynchronous to clock.
- rx_data  output  8  holding register contents; meaningful only while rx_valid=1.
- rx_valid  output  1  holding register contains an unread byte.
- rx_ready  input  1  consumer accepts the byte on a cycle where rx_valid&rx_ready=1.
- frame_error  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: a good byte was dropped because the holding register was full.
- rx_busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (async assert, sync deassert by the caller's reset tree):
  - Synchronizer flops = 1; state = IDLE; bit counter = 0; cycle counter = 0.
  - rx_data = 8'h00; rx_valid = 0; frame_error = 0; overrun = 0; rx_busy = 0.
  - Reset mid-frame aborts the frame. No partial byte is ever presented.
- Synchronizer: two flops on uart_rx_input. All logic uses the second-flop output `rxs`, which adds 2 cycles of latency.
- States: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE:
  - When rxs=0, go to START and clear the cycle counter.
- START:
  - Count to (CLKS_PER_BIT/2)-1 (integer divide), then sample rxs.
  - rxs=1: false start (glitch). Return to IDLE with no flags.
  - rxs=0: go to DATA; clear the cycle counter and bit counter.
- DATA:
  - At each count of CLKS_PER_BIT-1, sample rxs into shift register bit [bit counter] (LSB first) and increment the bit counter.
  - After the 8th sample, go to STOP.
- STOP:
  - At count CLKS_PER_BIT-1, sample rxs.
  - rxs=1: byte complete (see load rules); go to IDLE.
  - rxs=0: pulse frame_error for 1 cycle, discard the byte, go to WAIT_HIGH.
- WAIT_HIGH:
  - Stay until rxs=1, then go to IDLE.
  - A break (line held low) therefore yields exactly one frame_error and no further frames.
- Cycle counter: 16 bits. Cleared on every state transition and on every bit sample.
- Load rules (evaluated in the stop-sample cycle; register updates are visible on the next edge):
  - rx_valid=0: load rx_data, set rx_valid=1.
  - rx_valid=1 and rx_ready=1 in the same cycle: load the new byte; rx_valid stays 1; no overrun.
  - rx_valid=1 and rx_ready=0: keep the old rx_data; pulse overrun for 1 cycle; the new byte is lost.
- Handshake:
  - rx_valid clears on the edge after a cycle with rx_valid&rx_ready=1, unless a new byte loads in that same cycle.
  - rx_data is stable while rx_valid=1 and no handshake occurs.
  - rx_ready while rx_valid=0 has no effect.
- Latency:
  - The stop-sample cycle falls 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after the falling start edge, referenced to the clock edge that first registers the low in flop 1.
  - rx_valid rises on the next edge.
- Back-to-back frames:
  - The transition to IDLE at mid-stop-bit allows a start edge arriving at the nominal end of the stop bit to be detected.
  - Frames are sustained with no idle gap.
- frame_error and overrun never assert in the same cycle, because they come from mutually exclusive stop-bit outcomes.

Test Plan (CLKS_PER_BIT=16 unless noted):
1. Reset, line idle high, send 8'hA5 at 16 clocks/bit, rx_ready=0 → rx_valid rises once, rx_data=8'hA5, no error pulses; raise rx_ready for 1 cycle → rx_valid=0 on the next edge.
2. Send 8'h3C then 8'hC3 back-to-back with no idle gap, rx_ready tied 1 → two valid cycles with rx_data=8'h3C then 8'hC3; overrun never asserts.
3. Send 8'h11 then 8'h22 with rx_ready=0 throughout → rx_data stays 8'h11, one overrun pulse at the second stop sample, rx_valid stays 1. Then assert rx_ready together with the completion of a third frame 8'h33 → rx_data=8'h33, rx_valid=1, no overrun.
4. 3-clock low glitch on an idle line → START aborts, rx_busy returns low, no rx_valid, no frame_error.
5. Frame 8'h55 with the stop bit driven low, then the line held low for 40 bit times, then released → exactly one frame_error pulse, no rx_valid; a following 8'h0F is received correctly.
6. Assert reset_n=0 during data bit 4 of 8'hFF, release, then send 8'h81 → no byte from the aborted frame, all outputs at reset values while in reset, then rx_data=8'h81 with rx_valid=1.
